// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD 8421 -> 5311 encoder.
// Digit width, FSM states and the 5311 code points.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIGIT_W-1:0] BCD5311_0 = 4'b0000;
    localparam logic [DIGIT_W-1:0] BCD5311_1 = 4'b0001;
    localparam logic [DIGIT_W-1:0] BCD5311_2 = 4'b0011;
    localparam logic [DIGIT_W-1:0] BCD5311_3 = 4'b0100;
    localparam logic [DIGIT_W-1:0] BCD5311_4 = 4'b0101;
    localparam logic [DIGIT_W-1:0] BCD5311_5 = 4'b0111;
    localparam logic [DIGIT_W-1:0] BCD5311_6 = 4'b1001;
    localparam logic [DIGIT_W-1:0] BCD5311_7 = 4'b1011;
    localparam logic [DIGIT_W-1:0] BCD5311_8 = 4'b1100;
    localparam logic [DIGIT_W-1:0] BCD5311_9 = 4'b1101;

    localparam logic [DIGIT_W-1:0] BCD5311_INVALID = 4'b0000;

endpackage

// File: rtl/bcd_digit_8421_to_5311.sv
// Combinational single-digit 8421 -> 5311 encoder.
// Codes 10..15 map to the invalid code and raise err.
module bcd_digit_8421_to_5311
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d8421,
    output logic [DIGIT_W-1:0] d5311,
    output logic               err
);

    // Lookup of the ten legal digits; anything above 9 is flagged
    always_comb begin
        d5311 = BCD5311_INVALID;
        err   = 1'b0;
        case (d8421)
            4'd0:    d5311 = BCD5311_0;
            4'd1:    d5311 = BCD5311_1;
            4'd2:    d5311 = BCD5311_2;
            4'd3:    d5311 = BCD5311_3;
            4'd4:    d5311 = BCD5311_4;
            4'd5:    d5311 = BCD5311_5;
            4'd6:    d5311 = BCD5311_6;
            4'd7:    d5311 = BCD5311_7;
            4'd8:    d5311 = BCD5311_8;
            4'd9:    d5311 = BCD5311_9;
            default: begin
                d5311 = BCD5311_INVALID;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bcd_8421_to_5311_encoder.sv
// Digit-serial BCD 8421 -> 5311 word encoder, one digit per clock.
// Words move in and out through valid/ready handshakes.
module bcd_8421_to_5311_encoder
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGIT_W*NDIG-1:0] in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*NDIG-1:0] out_bcd,
    output logic                    out_err,
    output logic [NDIG-1:0]         out_err_mask
);

    localparam int W     = DIGIT_W * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t             state;
    logic [W-1:0]       shreg;
    logic [IDX_W-1:0]   idx;
    logic [DIGIT_W-1:0] code;
    logic               derr;

    // The low nibble of the shift register is always the digit in flight
    bcd_digit_8421_to_5311 u_digit (
        .d8421 (shreg[DIGIT_W-1:0]),
        .d5311 (code),
        .err   (derr)
    );

    // Control FSM with registered handshakes and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            idx          <= '0;
            out_bcd      <= '0;
            out_err_mask <= '0;
            out_err      <= 1'b0;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg        <= in_bcd;
                        out_bcd      <= '0;
                        out_err_mask <= '0;
                        out_err      <= 1'b0;
                        idx          <= '0;
                        in_ready     <= 1'b0;
                        state        <= CONV;
                    end
                end
                CONV: begin
                    shreg <= shreg >> DIGIT_W;
                    out_bcd[int'(idx)*DIGIT_W +: DIGIT_W] <= code;
                    out_err_mask[idx] <= derr;
                    // Mask was cleared on accept, so a running OR
                    // equals the OR of the finished mask
                    out_err <= out_err | derr;
                    if (idx == LAST_IDX) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
